// File: rtl/uart_rx_mmio_pkg.sv
// Shared UART definitions: baud derivation, receiver FSM encoding and MMIO read-word layout.
package uart_rx_mmio_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MMIO_W    = 32;
    localparam int unsigned VALID_BIT = 31;
    localparam int unsigned OVR_BIT   = 30;
    localparam int unsigned FERR_BIT  = 29;

    // Clocks per bit; integer division so the transmitter derives the same value.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return baud_div(clk_freq, baud_rate) / 2;
    endfunction

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Field order mirrors VALID_BIT / OVR_BIT / FERR_BIT and data in [7:0].
    typedef struct packed {
        logic                           valid;
        logic                           overrun;
        logic                           frame_err;
        logic [MMIO_W-DATA_W-4:0]       rsvd;
        logic [DATA_W-1:0]              data;
    } rx_mmio_t;

endpackage

// File: rtl/uart_rx_mmio_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is readable without popping.
module uart_rx_mmio_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver feeding a receive FIFO, exposed as a read-to-pop MMIO status/data word.
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_pin,
    input  logic              bus_ren,
    output logic [MMIO_W-1:0] mmio_rdata,
    output logic              rx_valid
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_DIV = half_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rx_sync;

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_baud_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;

    logic              w_bit_tick;
    logic              w_push;
    logic              w_ferr_set;
    logic              w_ovr_set;
    logic              r_overrun;
    logic              r_frame_err;

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    rx_mmio_t          w_rdata;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_sync  = r_sync2;
    assign w_bit_tick = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
        end
    end

    // Start bit is checked at mid-bit, then every later sample lands one bit period on.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_baud_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_sync) w_state_nxt = START;
            end
            START: begin
                if (r_baud_cnt == CNT_W'(HALF_DIV - 1)) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_sync, r_shift[DATA_W-1:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                w_cnt_nxt = '0;
                if (w_rx_sync) w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        if (r_state == STOP && w_bit_tick) begin
            w_push     = w_rx_sync;
            w_ferr_set = ~w_rx_sync;
        end
    end

    assign w_ovr_set = w_push & w_full & ~(bus_ren & ~w_empty);

    // Sticky flags, cleared by any read; a coincident set event wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (bus_ren) r_overrun <= 1'b0;
            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (bus_ren) r_frame_err <= 1'b0;
        end
    end

    uart_rx_mmio_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (bus_ren),
        .i_data  (r_shift),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_rdata           = '0;
        w_rdata.valid     = ~w_empty;
        w_rdata.overrun   = r_overrun;
        w_rdata.frame_err = r_frame_err;
        w_rdata.data      = w_empty ? '0 : w_head;
    end

    assign mmio_rdata = w_rdata;
    assign rx_valid   = ~w_empty;

endmodule
